datapath_control_sequencer: RTL and testbench

DATAPATH_CONTROL_SEQUENCER -- requirements
Module: datapath_control_sequencer

---
 rtl/datapath_control_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_datapath_control_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/datapath_control_sequencer.sv
// Datapath control sequencer: decodes 32-bit instructions into a registered
// 24-bit datapath control word plus a 64-bit constant operand. Loads are
// expanded into LOAD_WAIT address words followed by one write-back word, and
// SKIPZ can suppress the next transferred instruction based on the Z flag.
module datapath_control_sequencer #(
   parameter int LOAD_WAIT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [3:0]  status,
   output logic [23:0] controlWord,
   output logic [63:0] K,
   output logic [3:0]  flags
);

   localparam logic [3:0] OP_MOVI  = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_ADDI  = 4'd3;
   localparam logic [3:0] OP_SUB   = 4'd4;
   localparam logic [3:0] OP_XOR   = 4'd5;
   localparam logic [3:0] OP_LSL   = 4'd6;
   localparam logic [3:0] OP_LSR   = 4'd7;
   localparam logic [3:0] OP_STUR  = 4'd8;
   localparam logic [3:0] OP_LDUR  = 4'd9;
   localparam logic [3:0] OP_SUBS  = 4'd10;
   localparam logic [3:0] OP_SKIPZ = 4'd11;
   localparam logic [1:0] LW       = 2'(LOAD_WAIT);

   typedef enum logic [1:0] {
      ST_ISSUE   = 2'd0,
      ST_LD_ADDR = 2'd1,
      ST_LD_WB   = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_cnt;
   logic [23:0] r_cw;
   logic [63:0] r_k;
   logic [3:0]  r_flags;
   logic        r_skip;
   logic        r_is_subs;
   logic [4:0]  r_ld_rd;
   logic [4:0]  r_ld_rn;
   logic [12:0] r_ld_imm;

   logic [3:0]  w_op;
   logic [4:0]  w_rd;
   logic [4:0]  w_rn;
   logic [4:0]  w_rm;
   logic [12:0] w_imm;
   logic        w_xfer;
   logic        w_exec;
   logic        w_ld_start;
   logic        w_z;
   logic        w_skip_nxt;
   logic        w_is_subs_nxt;
   logic [23:0] w_cw_nxt;
   logic [63:0] w_k_nxt;

   // Pack the individual control fields into the datapath word layout.
   function automatic logic [23:0] f_cw(input logic [4:0] da, input logic [4:0] sa,
                                        input logic [4:0] sb, input logic [4:0] fs,
                                        input logic regw, input logic ramw,
                                        input logic selalu, input logic selk);
      return {da, sa, sb, fs, regw, ramw, selalu, selk};
   endfunction

   // Load words: address phase has no destination, write-back targets rd.
   function automatic logic [23:0] f_ld(input logic [4:0] rd, input logic [4:0] rn,
                                        input logic wb);
      return f_cw(wb ? rd : 5'd0, rn, 5'd0, 5'b01000, wb, 1'b0, 1'b0, 1'b1);
   endfunction

   // Single-word decode of a freshly transferred instruction.
   function automatic logic [23:0] f_decode(input logic [3:0] op, input logic [4:0] rd,
                                            input logic [4:0] rn, input logic [4:0] rm);
      case (op)
         OP_MOVI:         return f_cw(rd, 5'd31, 5'd0, 5'b00100, 1'b1, 1'b0, 1'b1, 1'b1);
         OP_ADD:          return f_cw(rd, rn, rm, 5'b01000, 1'b1, 1'b0, 1'b1, 1'b0);
         OP_ADDI:         return f_cw(rd, rn, 5'd0, 5'b01000, 1'b1, 1'b0, 1'b1, 1'b1);
         OP_SUB, OP_SUBS: return f_cw(rd, rn, rm, 5'b01011, 1'b1, 1'b0, 1'b1, 1'b0);
         OP_XOR:          return f_cw(rd, rn, rm, 5'b01100, 1'b1, 1'b0, 1'b1, 1'b0);
         OP_LSL:          return f_cw(rd, rn, 5'd0, 5'b10000, 1'b1, 1'b0, 1'b1, 1'b1);
         OP_LSR:          return f_cw(rd, rn, 5'd0, 5'b10100, 1'b1, 1'b0, 1'b1, 1'b1);
         OP_STUR:         return f_cw(5'd0, rn, rd, 5'b01000, 1'b0, 1'b1, 1'b1, 1'b1);
         OP_LDUR:         return f_ld(rd, rn, 1'b0);
         default:         return 24'd0;
      endcase
   endfunction

   assign w_op   = instr[31:28];
   assign w_rd   = instr[27:23];
   assign w_rn   = instr[22:18];
   assign w_rm   = instr[17:13];
   assign w_imm  = instr[12:0];

   assign instr_ready = ~reset & (r_state != ST_LD_ADDR);
   assign w_xfer      = instr_valid & instr_ready;
   assign w_exec      = w_xfer & ~r_skip;
   assign w_ld_start  = w_exec & (w_op == OP_LDUR);
   // Z is forwarded from the live ALU status when a SUBS word is on the bus.
   assign w_z         = r_is_subs ? status[0] : r_flags[0];

   assign controlWord = r_cw;
   assign K           = r_k;
   assign flags       = r_flags;

   // State register plus all registered outputs and load bookkeeping.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= ST_ISSUE;
         r_cnt     <= 2'd0;
         r_cw      <= 24'd0;
         r_k       <= 64'd0;
         r_flags   <= 4'd0;
         r_skip    <= 1'b0;
         r_is_subs <= 1'b0;
         r_ld_rd   <= 5'd0;
         r_ld_rn   <= 5'd0;
         r_ld_imm  <= 13'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_cw      <= w_cw_nxt;
         r_k       <= w_k_nxt;
         r_skip    <= w_skip_nxt;
         r_is_subs <= w_is_subs_nxt;
         if (r_is_subs) begin
            r_flags <= status;
         end
         if (w_ld_start) begin
            r_cnt    <= 2'd1;
            r_ld_rd  <= w_rd;
            r_ld_rn  <= w_rn;
            r_ld_imm <= w_imm;
         end else if (r_state == ST_LD_ADDR && r_cnt != LW) begin
            r_cnt <= r_cnt + 2'd1;
         end else begin
            r_cnt <= 2'd0;
         end
      end
   end

   // Next-state logic for the load sequencing FSM.
   always_comb begin
      w_state_nxt = ST_ISSUE;
      case (r_state)
         ST_ISSUE: begin
            if (w_ld_start) w_state_nxt = ST_LD_ADDR;
            else            w_state_nxt = ST_ISSUE;
         end
         ST_LD_ADDR: begin
            if (r_cnt == LW) w_state_nxt = ST_LD_WB;
            else             w_state_nxt = ST_LD_ADDR;
         end
         ST_LD_WB: begin
            if (w_ld_start) w_state_nxt = ST_LD_ADDR;
            else            w_state_nxt = ST_ISSUE;
         end
         default: w_state_nxt = ST_ISSUE;
      endcase
   end

   // Next control word, constant and skip/flag-forwarding bookkeeping.
   always_comb begin
      w_cw_nxt      = 24'd0;
      w_k_nxt       = 64'd0;
      w_is_subs_nxt = 1'b0;
      w_skip_nxt    = r_skip;
      if (r_state == ST_LD_ADDR) begin
         w_cw_nxt = f_ld(r_ld_rd, r_ld_rn, r_cnt == LW);
         w_k_nxt  = {51'd0, r_ld_imm};
      end else if (w_exec) begin
         w_cw_nxt      = f_decode(w_op, w_rd, w_rn, w_rm);
         w_is_subs_nxt = (w_op == OP_SUBS);
         if (w_op >= OP_MOVI && w_op <= OP_SUBS) w_k_nxt = {51'd0, w_imm};
         else                                    w_k_nxt = 64'd0;
      end else begin
         w_cw_nxt = 24'd0;
      end
      if (w_xfer) begin
         if (r_skip)                  w_skip_nxt = 1'b0;
         else if (w_op == OP_SKIPZ)   w_skip_nxt = w_z;
         else                         w_skip_nxt = 1'b0;
      end else begin
         w_skip_nxt = r_skip;
      end
   end

endmodule

// File: tb/tb_datapath_control_sequencer.sv
// Directed bench for datapath_control_sequencer: every driven cycle pushes the
// expected next control word/constant into a scoreboard queue, which is popped
// and compared after the following rising edge.
module tb_datapath_control_sequencer;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [3:0]  status;
   logic [23:0] controlWord;
   logic [63:0] K;
   logic [3:0]  flags;

   typedef struct {
      logic [23:0] cw;
      logic [63:0] k;
      string       tag;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   datapath_control_sequencer #(.LOAD_WAIT(1)) dut (
      .clock       (clock),
      .reset       (reset),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .status      (status),
      .controlWord (controlWord),
      .K           (K),
      .flags       (flags)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rn, input logic [4:0] rm,
                                      input logic [12:0] imm);
      return {op, rd, rn, rm, imm};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: drive inputs, push expectation, clock, pop and compare.
   task automatic step(input logic rst, input logic v, input logic [31:0] ins,
                       input logic [3:0] st, input logic [23:0] ecw,
                       input logic [63:0] ek, input string tag);
      exp_t e;
      reset       = rst;
      instr_valid = v;
      instr       = ins;
      status      = st;
      e.cw = ecw; e.k = ek; e.tag = tag;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      e = sb_q.pop_front();
      chk({e.tag, "_cw"}, {40'd0, controlWord}, {40'd0, e.cw});
      chk({e.tag, "_k"}, K, e.k);
   endtask

   initial begin
      reset = 1'b1; instr_valid = 1'b0; instr = 32'd0; status = 4'd0;
      step(1'b1, 1'b0, 32'd0, 4'd0, 24'h0, 64'd0, "rst0");
      step(1'b1, 1'b1, mk(4'd1, 5'd5, 5'd0, 5'd0, 13'd24), 4'd0, 24'h0, 64'd0, "rst1");
      chk("rst_flags", {60'd0, flags}, 64'd0);
      chk("rst_ready", {63'd0, instr_ready}, 64'd0);
      reset = 1'b0;
      #1;
      chk("ready_issue", {63'd0, instr_ready}, 64'd1);

      step(1'b0, 1'b1, mk(4'd1, 5'd5, 5'd0, 5'd0, 13'd24), 4'd0, 24'h2FC04B, 64'd24, "movi");
      step(1'b0, 1'b0, 32'd0, 4'd0, 24'h0, 64'd0, "idle1");
      step(1'b0, 1'b1, mk(4'd2, 5'd1, 5'd5, 5'd7, 13'd0), 4'd0, 24'h094E8A, 64'd0, "add");
      step(1'b0, 1'b1, mk(4'd5, 5'd30, 5'd1, 5'd5, 13'd0), 4'd0, 24'hF04ACA, 64'd0, "xor");
      step(1'b0, 1'b0, 32'd0, 4'd0, 24'h0, 64'd0, "idle2");
      step(1'b0, 1'b1, mk(4'd3, 5'd3, 5'd2, 5'd0, 13'h1FFF), 4'd0, 24'h18808B, 64'h1FFF, "addi");
      step(1'b0, 1'b1, mk(4'd8, 5'd9, 5'd3, 5'd0, 13'd5), 4'd0, 24'h00D287, 64'd5, "stur");
      step(1'b0, 1'b1, mk(4'd6, 5'd4, 5'd6, 5'd0, 13'd3), 4'd0, 24'h21810B, 64'd3, "lsl");
      step(1'b0, 1'b1, mk(4'd7, 5'd4, 5'd6, 5'd0, 13'd3), 4'd0, 24'h21814B, 64'd3, "lsr");
      step(1'b0, 1'b1, mk(4'd13, 5'd4, 5'd6, 5'd1, 13'd3), 4'd0, 24'h0, 64'd0, "op13");

      // Load with an ignored instruction offered during the address phase.
      step(1'b0, 1'b1, mk(4'd9, 5'd0, 5'd7, 5'd0, 13'd0), 4'd0, 24'h01C081, 64'd0, "ld_addr");
      chk("ld_addr_ready", {63'd0, instr_ready}, 64'd0);
      step(1'b0, 1'b1, mk(4'd1, 5'd5, 5'd0, 5'd0, 13'd24), 4'd0, 24'h01C089, 64'd0, "ld_wb");
      chk("ld_wb_ready", {63'd0, instr_ready}, 64'd1);
      step(1'b0, 1'b0, 32'd0, 4'd0, 24'h0, 64'd0, "ld_done");

      // Load with a back-to-back transfer accepted in the write-back cycle.
      step(1'b0, 1'b1, mk(4'd9, 5'd2, 5'd4, 5'd0, 13'd6), 4'd0, 24'h010081, 64'd6, "ld2_addr");
      step(1'b0, 1'b0, 32'd0, 4'd0, 24'h110089, 64'd6, "ld2_wb");
      step(1'b0, 1'b1, mk(4'd1, 5'd5, 5'd0, 5'd0, 13'd24), 4'd0, 24'h2FC04B, 64'd24, "b2b_movi");
      step(1'b0, 1'b0, 32'd0, 4'd0, 24'h0, 64'd0, "idle3");

      // SUBS sets Z, forwarded SKIPZ suppresses ADDI.
      step(1'b0, 1'b1, mk(4'd10, 5'd2, 5'd3, 5'd4, 13'd0), 4'd0, 24'h10C8BA, 64'd0, "subs1");
      step(1'b0, 1'b1, mk(4'd11, 5'd0, 5'd0, 5'd0, 13'd0), 4'b0001, 24'h0, 64'd0, "skipz1");
      chk("flags_z", {60'd0, flags}, 64'd1);
      step(1'b0, 1'b1, mk(4'd3, 5'd3, 5'd2, 5'd0, 13'h1FFF), 4'd0, 24'h0, 64'd0, "skipped_addi");
      step(1'b0, 1'b1, mk(4'd2, 5'd1, 5'd2, 5'd3, 13'd0), 4'd0, 24'h08868A, 64'd0, "add_after");

      // SKIPZ using held flags; a skipped SKIPZ arms nothing.
      step(1'b0, 1'b1, mk(4'd11, 5'd0, 5'd0, 5'd0, 13'd0), 4'd0, 24'h0, 64'd0, "skipz2");
      step(1'b0, 1'b1, mk(4'd11, 5'd0, 5'd0, 5'd0, 13'd0), 4'd0, 24'h0, 64'd0, "skipz3");
      step(1'b0, 1'b1, mk(4'd2, 5'd1, 5'd2, 5'd3, 13'd0), 4'd0, 24'h08868A, 64'd0, "add_noskip");

      // Forwarded Z=0 overrides stale flags Z=1.
      step(1'b0, 1'b1, mk(4'd10, 5'd2, 5'd3, 5'd4, 13'd0), 4'd0, 24'h10C8BA, 64'd0, "subs2");
      step(1'b0, 1'b1, mk(4'd11, 5'd0, 5'd0, 5'd0, 13'd0), 4'b1010, 24'h0, 64'd0, "skipz4");
      chk("flags_1010", {60'd0, flags}, 64'hA);
      step(1'b0, 1'b1, mk(4'd3, 5'd3, 5'd2, 5'd0, 13'h1FFF), 4'd0, 24'h18808B, 64'h1FFF, "addi_exec");

      // Skipped LDUR enters no load states.
      step(1'b0, 1'b1, mk(4'd10, 5'd2, 5'd3, 5'd4, 13'd0), 4'd0, 24'h10C8BA, 64'd0, "subs3");
      step(1'b0, 1'b1, mk(4'd11, 5'd0, 5'd0, 5'd0, 13'd0), 4'b0001, 24'h0, 64'd0, "skipz5");
      step(1'b0, 1'b1, mk(4'd9, 5'd0, 5'd7, 5'd0, 13'd0), 4'd0, 24'h0, 64'd0, "skipped_ldur");
      chk("skip_ld_ready", {63'd0, instr_ready}, 64'd1);
      step(1'b0, 1'b1, mk(4'd2, 5'd1, 5'd2, 5'd3, 13'd0), 4'd0, 24'h08868A, 64'd0, "add_after_ld");

      // Reset during the address phase aborts the load.
      step(1'b0, 1'b1, mk(4'd9, 5'd0, 5'd7, 5'd0, 13'd0), 4'd0, 24'h01C081, 64'd0, "ld3_addr");
      step(1'b1, 1'b1, mk(4'd1, 5'd5, 5'd0, 5'd0, 13'd24), 4'd0, 24'h0, 64'd0, "ld3_rst");
      chk("ld3_rst_flags", {60'd0, flags}, 64'd0);
      chk("ld3_rst_ready", {63'd0, instr_ready}, 64'd0);
      step(1'b0, 1'b0, 32'd0, 4'd0, 24'h0, 64'd0, "ld3_no_wb");
      chk("ld3_ready", {63'd0, instr_ready}, 64'd1);
      step(1'b0, 1'b1, mk(4'd1, 5'd5, 5'd0, 5'd0, 13'd24), 4'd0, 24'h2FC04B, 64'd24, "movi_after_rst");

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
